// File: rtl/nmea_frame_parser.sv
// NMEA frame parser: streams data-field characters, checks the XOR checksum, reports per-frame status.
// Optional feature: define NMEA_TIMEOUT_EN to abort a frame after TIMEOUT_CYC idle cycles.
module nmea_frame_parser #(
    parameter int N_TI        = 2,
    parameter int N_SI        = 3,
    parameter int MAX_CHARS   = 82,
    parameter int MAX_FIELDS  = 32,
    parameter int TIMEOUT_CYC = 100000,
    localparam int FW         = $clog2(MAX_FIELDS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_char,
    input  logic              i_valid,
    output logic [8*N_TI-1:0] o_tid,
    output logic [8*N_SI-1:0] o_sid,
    output logic [7:0]        o_field_char,
    output logic              o_field_valid,
    output logic              o_field_end,
    output logic [FW-1:0]     o_field_idx,
    output logic [FW-1:0]     o_field_cnt,
    output logic              o_done,
    output logic              o_ok,
    output logic [2:0]        o_err
);
    localparam int LW  = $clog2(MAX_CHARS + 2);
    localparam int IDW = $clog2(N_TI + N_SI + 1);
    localparam int TW  = 8 * N_TI;
    localparam int SW  = 8 * N_SI;

    localparam logic [2:0] E_NONE   = 3'd0;
    localparam logic [2:0] E_CKSUM  = 3'd1;
    localparam logic [2:0] E_HEX    = 3'd2;
    localparam logic [2:0] E_LEN    = 3'd3;
    localparam logic [2:0] E_FRAME  = 3'd4;
    localparam logic [2:0] E_FIELDS = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_TI, S_SI, S_DATA, S_CK_HI, S_CK_LO, S_CR, S_LF
    } state_t;

    state_t         r_state;
    logic [LW-1:0]  r_len;
    logic [IDW-1:0] r_idCnt;
    logic [FW-1:0]  r_idx;
    logic [7:0]     r_ck;
    logic [7:0]     r_rxCk;

    logic [LW-1:0]  w_lenNext;
    logic           w_counted;
    logic           w_lenErr;
    logic           w_isHex;
    logic [3:0]     w_nib;

`ifdef NMEA_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    logic [TOW-1:0] r_idle;
`endif

    always_comb begin
        w_isHex = 1'b0;
        w_nib   = 4'd0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            w_isHex = 1'b1;
            w_nib   = 4'(i_char - 8'h30);
        end else if (i_char >= 8'h41 && i_char <= 8'h46) begin
            w_isHex = 1'b1;
            w_nib   = 4'(i_char - 8'h37);
        end
    end

    // Length covers '$' through the second checksum digit; CR/LF are not counted.
    assign w_counted = (r_state == S_TI) || (r_state == S_SI) || (r_state == S_DATA) ||
                       (r_state == S_CK_HI) || (r_state == S_CK_LO);
    assign w_lenNext = r_len + 1'b1;
    assign w_lenErr  = w_counted && (w_lenNext > LW'(MAX_CHARS));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_idCnt       <= '0;
            r_idx         <= '0;
            r_ck          <= '0;
            r_rxCk        <= '0;
            o_tid         <= '0;
            o_sid         <= '0;
            o_field_char  <= '0;
            o_field_valid <= 1'b0;
            o_field_end   <= 1'b0;
            o_field_idx   <= '0;
            o_field_cnt   <= '0;
            o_done        <= 1'b0;
            o_ok          <= 1'b0;
            o_err         <= E_NONE;
`ifdef NMEA_TIMEOUT_EN
            r_idle        <= '0;
`endif
        end else begin
            o_done        <= 1'b0;
            o_ok          <= 1'b0;
            o_field_valid <= 1'b0;
            o_field_end   <= 1'b0;
            if (i_valid) begin
`ifdef NMEA_TIMEOUT_EN
                r_idle <= '0;
`endif
                // A '$' in LF is treated as a bad terminator, not as a resync.
                if (i_char == 8'h24 && r_state != S_LF) begin
                    if (r_state != S_IDLE) begin
                        o_done <= 1'b1;
                        o_err  <= E_FRAME;
                    end else begin
                        o_err  <= E_NONE;
                    end
                    r_state     <= S_TI;
                    r_len       <= LW'(1);
                    r_ck        <= '0;
                    r_idCnt     <= '0;
                    r_idx       <= '0;
                    o_field_idx <= '0;
                end else if (w_lenErr) begin
                    o_done  <= 1'b1;
                    o_err   <= E_LEN;
                    r_state <= S_IDLE;
                end else begin
                    if (w_counted) r_len <= w_lenNext;
                    case (r_state)
                        S_IDLE: begin
                        end
                        S_TI: begin
                            r_ck  <= r_ck ^ i_char;
                            o_tid <= (o_tid << 8) | TW'(i_char);
                            if (r_idCnt == IDW'(N_TI - 1)) begin
                                r_idCnt <= '0;
                                r_state <= S_SI;
                            end else begin
                                r_idCnt <= r_idCnt + 1'b1;
                            end
                        end
                        S_SI: begin
                            r_ck  <= r_ck ^ i_char;
                            o_sid <= (o_sid << 8) | SW'(i_char);
                            if (r_idCnt == IDW'(N_SI - 1)) begin
                                r_idCnt <= '0;
                                r_state <= S_DATA;
                            end else begin
                                r_idCnt <= r_idCnt + 1'b1;
                            end
                        end
                        S_DATA: begin
                            // o_field_idx shows the field being closed, r_idx the one being filled.
                            if (i_char == 8'h2C) begin
                                if (r_idx == FW'(MAX_FIELDS)) begin
                                    o_done  <= 1'b1;
                                    o_err   <= E_FIELDS;
                                    r_state <= S_IDLE;
                                end else begin
                                    r_ck        <= r_ck ^ i_char;
                                    o_field_end <= (r_idx != '0);
                                    o_field_idx <= r_idx;
                                    r_idx       <= r_idx + 1'b1;
                                end
                            end else if (i_char == 8'h2A) begin
                                o_field_end <= (r_idx != '0);
                                o_field_idx <= r_idx;
                                o_field_cnt <= r_idx;
                                r_state     <= S_CK_HI;
                            end else begin
                                r_ck          <= r_ck ^ i_char;
                                o_field_valid <= 1'b1;
                                o_field_char  <= i_char;
                                o_field_idx   <= r_idx;
                            end
                        end
                        S_CK_HI, S_CK_LO: begin
                            if (!w_isHex) begin
                                o_done  <= 1'b1;
                                o_err   <= E_HEX;
                                r_state <= S_IDLE;
                            end else if (r_state == S_CK_HI) begin
                                r_rxCk[7:4] <= w_nib;
                                r_state     <= S_CK_LO;
                            end else begin
                                r_rxCk[3:0] <= w_nib;
                                r_state     <= S_CR;
                            end
                        end
                        S_CR: begin
                            if (i_char == 8'h0D) begin
                                r_state <= S_LF;
                            end else begin
                                o_done  <= 1'b1;
                                o_err   <= E_FRAME;
                                r_state <= S_IDLE;
                            end
                        end
                        S_LF: begin
                            o_done  <= 1'b1;
                            r_state <= S_IDLE;
                            if (i_char != 8'h0A) begin
                                o_err <= E_FRAME;
                            end else begin
                                o_ok  <= (r_rxCk == r_ck);
                                o_err <= (r_rxCk == r_ck) ? E_NONE : E_CKSUM;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
`ifdef NMEA_TIMEOUT_EN
            else if (r_state != S_IDLE) begin
                if (r_idle == TOW'(TIMEOUT_CYC - 1)) begin
                    o_done  <= 1'b1;
                    o_err   <= 3'd6;
                    r_state <= S_IDLE;
                    r_idle  <= '0;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_nmea_frame_parser.sv
// Scoreboard bench for nmea_frame_parser: a frame generator predicts every output event from
// the frame it builds, and an independent monitor pops and compares whenever the DUT emits one.
module tb_nmea_frame_parser;
    localparam int N_TI       = 2;
    localparam int N_SI       = 3;
    localparam int MAX_CHARS  = 16;
    localparam int MAX_FIELDS = 2;
    localparam int FW         = $clog2(MAX_FIELDS + 1);

    typedef enum int {EV_NONE, EV_CHAR, EV_END, EV_DONE} evKind_t;
    typedef enum int {R_DOLLAR, R_ID, R_COMMA, R_FCHAR, R_STAR, R_CKH, R_CKL, R_CR, R_LF} role_t;

    typedef struct {
        evKind_t     kind;
        int          stamp;
        logic [7:0]  ch;
        int          idx;
        logic        ok;
        logic [2:0]  err;
        logic        chkIds;
        logic [15:0] tid;
        logic [23:0] sid;
        int          cnt;
    } ev_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           i_char;
    logic                 i_valid;
    logic [8*N_TI-1:0]    o_tid;
    logic [8*N_SI-1:0]    o_sid;
    logic [7:0]           o_field_char;
    logic                 o_field_valid;
    logic                 o_field_end;
    logic [FW-1:0]        o_field_idx;
    logic [FW-1:0]        o_field_cnt;
    logic                 o_done;
    logic                 o_ok;
    logic [2:0]           o_err;

    ev_t   expQ[$];
    string fld[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    expCnt = 0;
    int    gapMax = 0;

    nmea_frame_parser #(
        .N_TI(N_TI), .N_SI(N_SI), .MAX_CHARS(MAX_CHARS),
        .MAX_FIELDS(MAX_FIELDS), .TIMEOUT_CYC(50)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_char(i_char), .i_valid(i_valid),
        .o_tid(o_tid), .o_sid(o_sid), .o_field_char(o_field_char),
        .o_field_valid(o_field_valid), .o_field_end(o_field_end),
        .o_field_idx(o_field_idx), .o_field_cnt(o_field_cnt),
        .o_done(o_done), .o_ok(o_ok), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic isHex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46);
    endfunction

    function automatic logic [7:0] hexDigit(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    function automatic ev_t mkEv(input evKind_t k);
        ev_t e;
        e.kind = k; e.stamp = 0; e.ch = 8'h00; e.idx = 0; e.ok = 1'b0; e.err = 3'd0;
        e.chkIds = 1'b0; e.tid = '0; e.sid = '0; e.cnt = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one character; its expected output (if any) is due right after the sampling edge.
    task automatic applyStimulus(input logic [7:0] c, input ev_t e);
        int gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
        repeat (gap) begin @(posedge clk); #1; end
        if (e.kind != EV_NONE) begin
            e.stamp = cyc + 1;
            expQ.push_back(e);
        end
        i_char  = c;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    // fault: 0 none, 1 wrong checksum (xor arg), 2 non-hex digit (arg[0] picks high digit),
    // 3 bad CR, 4 bad LF. Fields come from fld. startErr marks the '$' as a resync.
    task automatic sendFrame(input logic [15:0] tid, input logic [23:0] sid,
                             input int fault, input int arg, input logic startErr);
        logic [7:0] chs[$];
        role_t      roles[$];
        int         tags[$];
        logic [7:0] ck = 8'h00;
        logic [7:0] ckSent, h, l, c;
        int         nF = fld.size();
        int         doneErr;
        ev_t        e;
        chs.push_back(8'h24); roles.push_back(R_DOLLAR); tags.push_back(0);
        for (int i = 0; i < N_TI; i++) begin
            c = tid[8*(N_TI-1-i) +: 8]; ck ^= c;
            chs.push_back(c); roles.push_back(R_ID); tags.push_back(0);
        end
        for (int i = 0; i < N_SI; i++) begin
            c = sid[8*(N_SI-1-i) +: 8]; ck ^= c;
            chs.push_back(c); roles.push_back(R_ID); tags.push_back(0);
        end
        for (int f = 0; f < nF; f++) begin
            ck ^= 8'h2C;
            chs.push_back(8'h2C); roles.push_back(R_COMMA); tags.push_back(f + 1);
            for (int k = 0; k < fld[f].len(); k++) begin
                c = fld[f][k]; ck ^= c;
                chs.push_back(c); roles.push_back(R_FCHAR); tags.push_back(f + 1);
            end
        end
        chs.push_back(8'h2A); roles.push_back(R_STAR); tags.push_back(0);
        ckSent = (fault == 1) ? (ck ^ 8'(arg)) : ck;
        h = hexDigit(ckSent[7:4]);
        l = hexDigit(ckSent[3:0]);
        if (fault == 2) begin
            if (arg[0]) h = 8'h47 + 8'((arg >> 1) % 20);
            else        l = 8'h47 + 8'((arg >> 1) % 20);
        end
        chs.push_back(h); roles.push_back(R_CKH); tags.push_back(0);
        chs.push_back(l); roles.push_back(R_CKL); tags.push_back(0);
        chs.push_back((fault == 3) ? 8'h58 : 8'h0D); roles.push_back(R_CR); tags.push_back(0);
        chs.push_back((fault == 4) ? 8'h59 : 8'h0A); roles.push_back(R_LF); tags.push_back(0);

        for (int i = 0; i < chs.size(); i++) begin
            int p = i + 1;
            e = mkEv(EV_NONE);
            doneErr = -1;
            if (roles[i] != R_DOLLAR && roles[i] != R_CR && roles[i] != R_LF && p > MAX_CHARS) begin
                doneErr = 3;
            end else begin
                case (roles[i])
                    R_DOLLAR: if (startErr) doneErr = 4;
                    R_COMMA: begin
                        if (tags[i] > MAX_FIELDS) doneErr = 5;
                        else if (tags[i] > 1) begin e = mkEv(EV_END); e.idx = tags[i] - 1; end
                    end
                    R_FCHAR: begin e = mkEv(EV_CHAR); e.ch = chs[i]; e.idx = tags[i]; end
                    R_STAR: begin
                        if (nF > 0) begin e = mkEv(EV_END); e.idx = nF; end
                        expCnt = nF;
                    end
                    R_CKH, R_CKL: if (!isHex(chs[i])) doneErr = 2;
                    R_CR: if (chs[i] != 8'h0D) doneErr = 4;
                    R_LF: doneErr = (chs[i] != 8'h0A) ? 4 : ((ckSent == ck) ? 0 : 1);
                    default: ;
                endcase
            end
            if (doneErr >= 0) begin
                e = mkEv(EV_DONE);
                e.err = 3'(doneErr); e.ok = (doneErr == 0); e.cnt = expCnt;
                e.chkIds = (roles[i] != R_DOLLAR); e.tid = tid; e.sid = sid;
            end
            applyStimulus(chs[i], e);
            if (doneErr >= 0 && roles[i] != R_DOLLAR) break;
        end
    endtask

    // Monitor: every field/done pulse must match the oldest outstanding prediction, on its cycle.
    ev_t monE;
    always @(negedge clk) begin
        if (!rst && (o_field_valid || o_field_end || o_done)) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_event: got valid=%0b end=%0b done=%0b err=%0d at cycle %0d, expected no event",
                         o_field_valid, o_field_end, o_done, o_err, cyc);
            end else begin
                logic good;
                monE = expQ.pop_front();
                good = (cyc == monE.stamp);
                case (monE.kind)
                    EV_CHAR: good = good && o_field_valid && !o_field_end && !o_done &&
                                    (o_field_char == monE.ch) && (int'(o_field_idx) == monE.idx);
                    EV_END:  good = good && o_field_end && !o_field_valid && !o_done &&
                                    (int'(o_field_idx) == monE.idx);
                    default: begin
                        good = good && o_done && !o_field_valid && !o_field_end && (o_ok == monE.ok) &&
                               (o_err == monE.err) && (int'(o_field_cnt) == monE.cnt);
                        if (monE.chkIds) good = good && (o_tid == monE.tid) && (o_sid == monE.sid);
                    end
                endcase
                if (!good) begin
                    errors++;
                    $display("[TB] FAIL %s: got cyc=%0d v=%0b e=%0b d=%0b ch=%02h idx=%0d ok=%0b err=%0d cnt=%0d tid=%h sid=%h, expected cyc=%0d ch=%02h idx=%0d ok=%0b err=%0d cnt=%0d tid=%h sid=%h",
                             monE.kind.name(), cyc, o_field_valid, o_field_end, o_done, o_field_char,
                             o_field_idx, o_ok, o_err, o_field_cnt, o_tid, o_sid, monE.stamp, monE.ch,
                             monE.idx, monE.ok, monE.err, monE.cnt, monE.tid, monE.sid);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no end of run, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        string pool = "0123456789.NSEWMK-";
        rst = 1'b1; i_char = 8'h00; i_valid = 1'b0;
        #12;
        checkOutput("reset_tid", 64'(o_tid), 64'h0);
        checkOutput("reset_sid", 64'(o_sid), 64'h0);
        checkOutput("reset_pulses", 64'({o_done, o_ok, o_field_valid, o_field_end}), 64'h0);
        checkOutput("reset_err", 64'(o_err), 64'h0);
        checkOutput("reset_idx_cnt", 64'({o_field_idx, o_field_cnt, o_field_char}), 64'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed frames");
        fld.delete();
        sendFrame(16'h4142, 24'h434445, 0, 0, 1'b0);
        checkOutput("plain_tid", 64'(o_tid), 64'h4142);
        checkOutput("plain_sid", 64'(o_sid), 64'h434445);

        fld = '{"1", "2"};
        sendFrame(16'h4750, 24'h58595A, 0, 0, 1'b0);
        checkOutput("two_field_cnt", 64'(o_field_cnt), 64'd2);
        sendFrame(16'h4750, 24'h58595A, 1, 1, 1'b0);

        fld.delete();
        sendFrame(16'h4142, 24'h434445, 2, 0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("err_hold_hex", 64'(o_err), 64'd2);
        sendFrame(16'h4142, 24'h434445, 0, 0, 1'b0);

        fld = '{"0000000000"};
        sendFrame(16'h4142, 24'h434445, 0, 0, 1'b0);
        fld = '{"", "", ""};
        sendFrame(16'h4142, 24'h434445, 0, 0, 1'b0);

        applyStimulus(8'h24, mkEv(EV_NONE));
        applyStimulus(8'h47, mkEv(EV_NONE));
        applyStimulus(8'h50, mkEv(EV_NONE));
        applyStimulus(8'h58, mkEv(EV_NONE));
        fld.delete();
        sendFrame(16'h4142, 24'h434445, 0, 0, 1'b1);
        fld = '{"7"};
        sendFrame(16'h4750, 24'h474741, 3, 0, 1'b0);
        sendFrame(16'h4750, 24'h474741, 4, 0, 1'b0);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(8'h24, mkEv(EV_NONE));
        applyStimulus(8'h41, mkEv(EV_NONE));
        applyStimulus(8'h42, mkEv(EV_NONE));
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_ids", 64'({o_tid, o_sid}), 64'h0);
        checkOutput("midreset_state", 64'({o_done, o_ok, o_err, o_field_cnt, o_field_idx}), 64'h0);
        rst = 1'b0;
        expCnt = 0;
        @(posedge clk); #1;
        fld.delete();
        sendFrame(16'h4142, 24'h434445, 0, 0, 1'b0);

        $display("[TB] randomized frames");
        gapMax = 2;
        for (int n = 0; n < 150; n++) begin
            int nF;
            int r;
            int fault;
            int arg;
            logic [15:0] tid;
            logic [23:0] sid;
            repeat ($urandom_range(0, 3)) applyStimulus(8'($urandom_range(8'h25, 8'h7E)), mkEv(EV_NONE));
            fld.delete();
            nF = $urandom_range(0, 3);
            for (int f = 0; f < nF; f++) begin
                string s = "";
                int len = $urandom_range(0, 4);
                for (int k = 0; k < len; k++) s = $sformatf("%s%c", s, pool[$urandom_range(0, pool.len() - 1)]);
                fld.push_back(s);
            end
            tid = {8'($urandom_range(65, 90)), 8'($urandom_range(65, 90))};
            sid = {8'($urandom_range(65, 90)), 8'($urandom_range(65, 90)), 8'($urandom_range(65, 90))};
            r = $urandom_range(0, 9);
            fault = (r <= 4) ? r : 0;
            arg = (fault == 1) ? int'($urandom_range(1, 255)) : int'($urandom_range(0, 63));
            sendFrame(tid, sid, fault, arg, 1'b0);
        end

        gapMax = 0;
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_events: got %0d outstanding, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
